// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, multi-cycle EX stalls and branch flushes.
// Optional HAZARD_PERF_CNT_EN adds load-stall, mc-stall and flush cycle counters.
module hazard_unit #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MC_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_1,
  input  logic [4:0] id_rs_2,
  input  logic       id_uses_rs_1,
  input  logic       id_uses_rs_2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_mc_start,
  input  logic       ex_mc_done,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       flush_if,
  output logic       flush_id,
  output logic       mc_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_load_stalls,
  output logic [31:0] perf_mc_stall_cycles,
  output logic [31:0] perf_flush_cycles
`endif
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MC_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [7:0] MC_MAX       = 8'(MC_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] mcnt_q, mcnt_d;
  logic       to_q, to_d;
  logic       load_use;
  logic       s_front, s_ex, s_bub, s_flush;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs_1 && (id_rs_1 == ex_rd)) ||
                     (id_uses_rs_2 && (id_rs_2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    mcnt_d  = mcnt_q;
    to_d    = to_q;
    s_front = 1'b0;
    s_ex    = 1'b0;
    s_bub   = 1'b0;
    s_flush = 1'b0;
    case (state_q)
      MC_WAIT: begin
        if (ex_mc_done) begin
          state_d = RUN;
        end else begin
          s_front = 1'b1;
          s_ex    = 1'b1;
          if (mcnt_q != MC_MAX) mcnt_d = mcnt_q + 8'd1;
          // Sticky: once the wait hits the limit, the flag stays until reset.
          if (mcnt_d == MC_MAX) to_d = 1'b1;
        end
      end
      FLUSH: begin
        s_flush = 1'b1;
        if (ex_branch_taken) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q <= 3'd1) begin
          fcnt_d  = 3'd0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: begin
        if (ex_branch_taken) begin
          s_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_RELOAD;
          end
        end else if (ex_mc_start && !ex_mc_done) begin
          s_front = 1'b1;
          s_ex    = 1'b1;
          state_d = MC_WAIT;
          mcnt_d  = 8'd1;
        end else if (!ex_mc_start && load_use) begin
          s_front = 1'b1;
          s_bub   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      mcnt_q  <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
      to_q    <= to_d;
    end
  end

  // Inputs feed the strobes combinationally, so gate them while reset is held.
  assign stall_if   = rst & s_front;
  assign stall_id   = rst & s_front;
  assign stall_ex   = rst & s_ex;
  assign bubble_ex  = rst & s_bub;
  assign flush_if   = rst & s_flush;
  assign flush_id   = rst & s_flush;
  assign mc_timeout = rst & to_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_load_stalls     <= 32'd0;
      perf_mc_stall_cycles <= 32'd0;
      perf_flush_cycles    <= 32'd0;
    end else begin
      if (s_bub)   perf_load_stalls     <= perf_load_stalls + 32'd1;
      if (s_ex)    perf_mc_stall_cycles <= perf_mc_stall_cycles + 32'd1;
      if (s_flush) perf_flush_cycles    <= perf_flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;
  localparam int FD = 2;
  localparam int MT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs_1 = '0, id_rs_2 = '0, ex_rd = '0;
  logic       id_uses_rs_1 = 1'b0, id_uses_rs_2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, ex_mc_start = 1'b0, ex_mc_done = 1'b0;
  logic       stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id, mc_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: flush cycles still owed, waiting flag, stalled-cycle count, sticky timeout.
  int m_flush_left = 0;
  bit m_mc         = 1'b0;
  int m_mc_cyc     = 0;
  bit m_to         = 1'b0;

  hazard_unit #(.FLUSH_DEPTH(FD), .MC_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .id_rs_1(id_rs_1), .id_rs_2(id_rs_2),
    .id_uses_rs_1(id_uses_rs_1), .id_uses_rs_2(id_uses_rs_2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .mc_timeout(mc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (stall_if,id,ex,bubble,flush_if,id,timeout)", tag, got, exp);
  endtask

  function automatic logic [6:0] outs();
    return {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id, mc_timeout};
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_mc = 1'b0; m_mc_cyc = 0; m_to = 1'b0;
  endtask

  task automatic set_in(input bit br, input bit mcs, input bit mcd, input bit rd_mem,
                        input int rd, input int r1, input bit u1, input int r2, input bit u2);
    ex_branch_taken = br; ex_mc_start = mcs; ex_mc_done = mcd; ex_mem_read = rd_mem;
    ex_rd = 5'(rd); id_rs_1 = 5'(r1); id_uses_rs_1 = u1; id_rs_2 = 5'(r2); id_uses_rs_2 = u2;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model past the edge.
  task automatic step(input string tag);
    bit   lu;
    bit   fl, st, sx, bb;
    int   nf, nc;
    bit   nmc, nto;
    @(negedge clk); #1;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs_1 && id_rs_1 == ex_rd) || (id_uses_rs_2 && id_rs_2 == ex_rd));
    fl = 0; st = 0; sx = 0; bb = 0;
    nf = m_flush_left; nmc = m_mc; nc = m_mc_cyc; nto = m_to;
    if (m_flush_left > 0) begin
      fl = 1;
      nf = ex_branch_taken ? FD - 1 : m_flush_left - 1;
    end else if (m_mc) begin
      if (ex_mc_done) nmc = 0;
      else begin
        st = 1; sx = 1;
        nc = (m_mc_cyc + 1 > MT) ? MT : m_mc_cyc + 1;
        if (nc == MT) nto = 1;
      end
    end else if (ex_branch_taken) begin
      fl = 1; nf = FD - 1;
    end else if (ex_mc_start && !ex_mc_done) begin
      st = 1; sx = 1; nmc = 1; nc = 1;
    end else if (!ex_mc_start && lu) begin
      st = 1; bb = 1;
    end
    chk(tag, outs(), {st, st, sx, bb, fl, fl, m_to});
    @(posedge clk); #1;
    m_flush_left = nf; m_mc = nmc; m_mc_cyc = nc; m_to = nto;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1, 0, 1, 5, 5, 1, 0, 0);
    #2 chk("reset_hold", outs(), 7'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Load-use on rs1, then inputs advance.
    set_in(0, 0, 0, 1, 5, 5, 1, 0, 0); step("load_use");
    set_in(0, 0, 0, 0, 5, 5, 1, 0, 0); step("load_use_clear");
    // x0 and unused-operand cases.
    set_in(0, 0, 0, 1, 0, 0, 1, 0, 1); step("x0_no_hazard");
    set_in(0, 0, 0, 1, 7, 1, 1, 7, 0); step("unused_rs2");
    set_in(0, 0, 0, 1, 7, 1, 0, 7, 1); step("load_use_rs2");
    // Branch with simultaneous load-use.
    set_in(1, 0, 0, 1, 5, 5, 1, 0, 0); step("branch_c1");
    set_in(0, 0, 0, 1, 5, 5, 1, 0, 0); step("branch_c2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("branch_done");
    // Multi-cycle op, done on the 4th cycle.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("mc_stall");
    set_in(0, 1, 1, 0, 0, 0, 0, 0, 0); step("mc_done");
    set_in(0, 1, 1, 1, 3, 3, 1, 0, 0); step("mc_same_cycle");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle");

    // Timeout: held with no done past the limit.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MT + 3; i++) step("mc_timeout_wait");
    set_in(0, 1, 1, 0, 0, 0, 0, 0, 0); step("mc_timeout_done");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mc_timeout_sticky");

    // Async reset mid-MC_WAIT, off a clock edge.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_async");
    @(negedge clk); #2;
    rst = 1'b0;
    #1 chk("async_reset", outs(), 7'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_async");

    // Randomized traffic on a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block, directly upstream of forwarding_unit.
- Decides when forwarding alone is not enough: load-use dependencies, taken branches, and multi-cycle EX operations (mul/div).
- Drives stall, bubble and flush strobes to the IF/ID and ID/EX pipeline registers. forwarding_unit only ever sees operand pairs that this block has allowed to advance.

Parameters:
- FLUSH_DEPTH, 2, cycles flush_if/flush_id stay high after a taken branch (covers fetch memory latency); legal range 1..7.
- MC_TIMEOUT, 64, max cycles EX may wait for mc_done before mc_timeout is raised; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- id_rs_1  input  5  rs1 index of the instruction in ID.
- id_rs_2  input  5  rs2 index of the instruction in ID.
- id_uses_rs_1  input  1  ID instruction reads rs1.
- id_uses_rs_2  input  1  ID instruction reads rs2.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rd  input  5  destination index of the instruction in EX.
- ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- ex_mc_start  input  1  EX holds a multi-cycle op not yet complete.
- ex_mc_done  input  1  multi-cycle unit result valid this cycle.
- stall_if  output  1  hold PC and IF/ID register.
- stall_id  output  1  hold ID/EX input side (ID instruction re-presented).
- stall_ex  output  1  hold EX/MEM input side (EX op in progress).
- bubble_ex  output  1  load a NOP into ID/EX.
- flush_if  output  1  clear IF/ID to NOP.
- flush_id  output  1  clear ID/EX to NOP.
- mc_timeout  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state=RUN, flush counter=0, mc counter=0, mc_timeout=0. All outputs are 0 while rst=0.
- Outputs are combinational from the registered state plus the current inputs; state updates on the rising edge of clk.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs_1 & id_rs_1==ex_rd) | (id_uses_rs_2 & id_rs_2==ex_rd)). Register x0 never causes a hazard.
- FSM states: RUN, MC_WAIT, FLUSH.
- RUN, priority order (first match wins):
  1. ex_branch_taken: flush_if=flush_id=1. If FLUSH_DEPTH>1, go to FLUSH with counter=FLUSH_DEPTH-1; else stay in RUN. A simultaneous load_use or ex_mc_start is ignored (the dependent instruction is being flushed; a branch never co-issues with a mc op).
  2. ex_mc_start & !ex_mc_done: stall_if=stall_id=stall_ex=1, bubble_ex=0. Go to MC_WAIT with counter=1.
  3. ex_mc_start & ex_mc_done: no stall; stay in RUN.
  4. load_use: stall_if=stall_id=1 and bubble_ex=1 for exactly this cycle; stay in RUN. The next cycle the load is in MEM, the hazard clears, and forwarding supplies the operand from WB.
  5. Otherwise all strobes 0.
- MC_WAIT:
  - stall_if=stall_id=stall_ex=1 every cycle until ex_mc_done=1.
  - In the ex_mc_done cycle all stalls drop to 0 (the result advances that cycle); return to RUN.
  - ex_branch_taken and load_use are ignored in MC_WAIT.
  - counter increments each cycle and saturates at MC_TIMEOUT. When counter reaches MC_TIMEOUT, mc_timeout is set and held until reset; stalls continue (no forced release).
- FLUSH:
  - flush_if=flush_id=1; counter decrements each cycle; go to RUN when counter==1 is consumed.
  - A new ex_branch_taken in FLUSH reloads counter=FLUSH_DEPTH-1 (EX is normally a NOP here).
  - Stall sources are ignored (the instructions are being discarded).
- stall_* and flush_* are never high in the same cycle. bubble_ex is only ever high together with stall_id.
- Reset asserted mid-MC_WAIT or mid-FLUSH aborts immediately to RUN with all outputs 0.

Optional Feature:
- HAZARD_PERF_CNT_EN: when defined, adds three 32-bit wrapping counters and output ports perf_load_stalls, perf_mc_stall_cycles and perf_flush_cycles.
  - Counters reset to 0 on rst.
  - Each increments once per cycle in which its condition drives a strobe.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs_1=5, id_uses_rs_1=1 for one cycle -> stall_if=stall_id=bubble_ex=1 that cycle only; all 0 the next cycle after inputs advance.
- x0 / unused operand: ex_rd=0 with id_rs_1=0, then ex_rd=7 with id_rs_2=7 and id_uses_rs_2=0 -> no stall in either case.
- Branch with FLUSH_DEPTH=2: ex_branch_taken pulse plus simultaneous load_use -> flush_if=flush_id=1 for 2 cycles, bubble_ex=0, then all 0.
- Multi-cycle: ex_mc_start held, ex_mc_done at the 4th cycle -> stall_if/id/ex=1 for 3 cycles, 0 in the done cycle; ex_mc_start & ex_mc_done in the same cycle -> 0 stalls.
- Timeout, MC_TIMEOUT=8: ex_mc_start held with no done -> mc_timeout rises after 8 stalled cycles and stays 1 after ex_mc_done; stalls persist until done.
- Async reset: rst=0 mid-MC_WAIT, off a clock edge -> all outputs 0 immediately; state RUN, mc_timeout=0 after release.
